// File: rtl/my_pkg.sv
// Shared types and constants for the data-memory interface.
// It holds the FSM state enum, the RV32I load/store size codes and the misalignment rule.
package my_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } dmem_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int unsigned CNT_W   = 4;
  localparam logic [3:0]  CNT_MAX = 4'hF;

  // Halfwords need an even address, words need a 4-byte-aligned address.
  function automatic logic is_misaligned(logic [2:0] f3, logic [1:0] off);
    logic mis;
    case (f3[1:0])
      LB[1:0]: mis = 1'b0;
      LH[1:0]: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_load_fmt.sv
// Combinational load formatter: picks the byte/halfword lane from a raw SRAM word
// and sign- or zero-extends it according to the registered funct3.
module dmem_load_fmt
  import my_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin : lane_sel
    case (offset_i)
      2'd0:    byte_c = rdata_i[7:0];
      2'd1:    byte_c = rdata_i[15:8];
      2'd2:    byte_c = rdata_i[23:16];
      default: byte_c = rdata_i[31:24];
    endcase
    half_c = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin : extend
    case (funct3_i)
      LB:      data_c = {{24{byte_c[7]}}, byte_c};
      LBU:     data_c = {24'd0, byte_c};
      LH:      data_c = {{16{half_c[15]}}, half_c};
      LHU:     data_c = {16'd0, half_c};
      default: data_c = rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_if.sv
// Pipeline-to-SRAM data memory interface: store lane formatting, variable-latency
// load sequencing with stall hold, misalignment detection and a startup-test override path.
module dmem_if
  import my_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter logic [31:0] TEST_ADDR    = 32'h0000_0001,
  parameter logic [31:0] TEST_PATTERN = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              chipselect_MEM,
  input  logic              write_enable_MEM,
  input  logic [2:0]        funct3_MEM,
  input  logic [31:0]       addr_MEM,
  input  logic [31:0]       wdata_MEM,
  input  logic              enable_cs,
  input  logic              STOP_Pipelinen,
  input  logic              TEST_EN,
  input  logic              TEST_MEM_CSB,
  input  logic              TEST_MEM_WE,
  input  logic [3:0]        rd_latency,
  input  logic [31:0]       MEM_RDATA,
  output logic              MEM_CSB,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [31:0]       MEM_WDATA,
  output logic [3:0]        MEM_WMASK,
  output logic [31:0]       rdata_WB,
  output logic              rdata_valid,
  output logic              misalign_err,
  output logic [31:0]       TEST_MEM_DATA
);

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             valid_q, valid_d;
  logic [31:0]      tdata_q, tdata_d;
  logic             err_q, err_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;

  logic             misaligned_c;
  logic             busy_c;
  logic             csb_path_c;
  logic             issue_rd_c;
  logic [CNT_W-1:0] lat_c;
  logic [31:0]      fmt_c;
  logic [3:0]       st_wmask_c;
  logic [31:0]      st_wdata_c;
  logic             unused_addr_c;

  assign unused_addr_c = ^addr_MEM[31:ADDR_W+2];

  assign misaligned_c = is_misaligned(funct3_MEM, addr_MEM[1:0]);
  // HOLD only blocks new requests while the pipeline is stalled.
  assign busy_c       = (state_q == WAIT) || ((state_q == HOLD) && !STOP_Pipelinen);
  assign csb_path_c   = enable_cs || busy_c || misaligned_c || chipselect_MEM;
  assign issue_rd_c   = !TEST_EN && !csb_path_c && write_enable_MEM;
  assign lat_c        = (rd_latency == 4'd0) ? 4'd1 : rd_latency;

  dmem_load_fmt u_load_fmt (
    .funct3_i (f3_q),
    .offset_i (off_q),
    .rdata_i  (MEM_RDATA),
    .data_c   (fmt_c)
  );

  always_comb begin : store_fmt
    st_wmask_c = 4'hF;
    st_wdata_c = wdata_MEM;
    case (funct3_MEM[1:0])
      SB[1:0]: begin
        st_wmask_c = 4'b0001 << addr_MEM[1:0];
        st_wdata_c = {4{wdata_MEM[7:0]}};
      end
      SH[1:0]: begin
        st_wmask_c = addr_MEM[1] ? 4'b1100 : 4'b0011;
        st_wdata_c = {2{wdata_MEM[15:0]}};
      end
      default: ;
    endcase
  end

  // SRAM port mux: the test path wins; reset always deselects the SRAM.
  always_comb begin : sram_mux
    MEM_CSB   = csb_path_c;
    MEM_WE    = write_enable_MEM;
    MEM_ADDR  = addr_MEM[ADDR_W+1:2];
    MEM_WDATA = st_wdata_c;
    MEM_WMASK = st_wmask_c;
    if (TEST_EN) begin
      MEM_CSB   = TEST_MEM_CSB;
      MEM_WE    = TEST_MEM_WE;
      MEM_ADDR  = TEST_ADDR[ADDR_W+1:2];
      MEM_WDATA = TEST_PATTERN;
      MEM_WMASK = 4'hF;
    end
    if (!rstn) begin
      MEM_CSB = 1'b1;
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    f3_d    = f3_q;
    off_d   = off_q;
    tdata_d = TEST_EN ? MEM_RDATA : tdata_q;
    err_d   = !TEST_EN && !chipselect_MEM && misaligned_c;
    if (TEST_EN) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        // >= lets a latency lowered mid-wait complete at once.
        WAIT: begin
          if (cnt_q >= lat_c) begin
            rdata_d = fmt_c;
            valid_d = 1'b1;
            state_d = HOLD;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        HOLD: begin
          if (STOP_Pipelinen) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (issue_rd_c) begin
        state_d = WAIT;
        cnt_d   = 4'd1;
        f3_d    = funct3_MEM;
        off_d   = addr_MEM[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin : regs
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      tdata_q <= '0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      tdata_q <= tdata_d;
      err_q   <= err_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  assign rdata_WB      = rdata_q;
  assign rdata_valid   = valid_q;
  assign misalign_err  = err_q;
  assign TEST_MEM_DATA = tdata_q;

endmodule

// File: tb/tb_dmem_if.sv
// Bench for dmem_if: directed scenarios with literal expectations plus a
// transaction-level reference model compared against the DUT every cycle.
module tb_dmem_if;

  localparam logic [31:0] TST_ADDR = 32'h0000_0001;
  localparam logic [31:0] TST_PAT  = 32'hFFFF_FFFF;

  logic        clk, rstn;
  logic        chipselect_MEM, write_enable_MEM;
  logic [2:0]  funct3_MEM;
  logic [31:0] addr_MEM, wdata_MEM;
  logic        enable_cs, STOP_Pipelinen;
  logic        TEST_EN, TEST_MEM_CSB, TEST_MEM_WE;
  logic [3:0]  rd_latency;
  logic [31:0] MEM_RDATA;
  logic        MEM_CSB, MEM_WE;
  logic [9:0]  MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_WMASK;
  logic [31:0] rdata_WB;
  logic        rdata_valid, misalign_err;
  logic [31:0] TEST_MEM_DATA;

  int n_checks = 0;
  int n_errors = 0;

  dmem_if dut (
    .clk(clk), .rstn(rstn),
    .chipselect_MEM(chipselect_MEM), .write_enable_MEM(write_enable_MEM),
    .funct3_MEM(funct3_MEM), .addr_MEM(addr_MEM), .wdata_MEM(wdata_MEM),
    .enable_cs(enable_cs), .STOP_Pipelinen(STOP_Pipelinen),
    .TEST_EN(TEST_EN), .TEST_MEM_CSB(TEST_MEM_CSB), .TEST_MEM_WE(TEST_MEM_WE),
    .rd_latency(rd_latency), .MEM_RDATA(MEM_RDATA),
    .MEM_CSB(MEM_CSB), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_WMASK(MEM_WMASK),
    .rdata_WB(rdata_WB), .rdata_valid(rdata_valid),
    .misalign_err(misalign_err), .TEST_MEM_DATA(TEST_MEM_DATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        wt;
    logic        hd;
    logic [3:0]  el;
    logic        valid;
    logic [31:0] rdata;
    logic [31:0] tdata;
    logic        err;
    logic [2:0]  f3;
    logic [1:0]  off;
  } mdl_t;

  mdl_t m;

  function automatic int acc_size(logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic mis(logic [2:0] f3, logic [31:0] a);
    return (int'(a[1:0]) % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] ld_fmt(logic [2:0] f3, logic [1:0] off, logic [31:0] w);
    logic [31:0] v;
    if (acc_size(f3) == 1) begin
      v = (w >> (8 * int'(off))) & 32'h0000_00FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (acc_size(f3) == 2) begin
      v = (w >> (16 * int'(off[1]))) & 32'h0000_FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic exp_csb();
    if (!rstn) return 1'b1;
    if (TEST_EN) return TEST_MEM_CSB;
    return enable_cs | m.wt | (m.hd & ~STOP_Pipelinen) | mis(funct3_MEM, addr_MEM) | chipselect_MEM;
  endfunction

  function automatic mdl_t model_next(mdl_t c);
    mdl_t n;
    logic iss;
    int   lat;
    n   = c;
    iss = !TEST_EN && !exp_csb() && write_enable_MEM;
    lat = (rd_latency == 4'd0) ? 1 : int'(rd_latency);
    n.err = !TEST_EN && !chipselect_MEM && mis(funct3_MEM, addr_MEM);
    if (TEST_EN) begin
      n.tdata = MEM_RDATA;
      n.wt = 1'b0; n.hd = 1'b0; n.valid = 1'b0; n.el = 4'd0;
    end else begin
      if (c.wt) begin
        if (int'(c.el) >= lat) begin
          n.rdata = ld_fmt(c.f3, c.off, MEM_RDATA);
          n.valid = 1'b1; n.wt = 1'b0; n.hd = 1'b1;
        end else if (c.el != 4'd15) begin
          n.el = c.el + 4'd1;
        end
      end else if (c.hd && STOP_Pipelinen) begin
        n.hd = 1'b0; n.valid = 1'b0;
      end
      if (iss) begin
        n.wt = 1'b1; n.hd = 1'b0; n.el = 4'd1;
        n.f3 = funct3_MEM; n.off = addr_MEM[1:0];
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m <= '0;
    else       m <= model_next(m);
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    logic [3:0]  emask;
    logic [31:0] ewdata;
    logic [9:0]  eaddr;
    if (TEST_EN) begin
      emask = 4'hF; ewdata = TST_PAT; eaddr = 10'(TST_ADDR >> 2);
    end else begin
      eaddr = 10'(addr_MEM >> 2);
      case (acc_size(funct3_MEM))
        1: begin emask = 4'(1 << addr_MEM[1:0]); ewdata = 32'(wdata_MEM[7:0]) * 32'h0101_0101; end
        2: begin emask = addr_MEM[1] ? 4'hC : 4'h3; ewdata = 32'(wdata_MEM[15:0]) * 32'h0001_0001; end
        default: begin emask = 4'hF; ewdata = wdata_MEM; end
      endcase
    end
    cmp("m_csb",   32'(MEM_CSB),      32'(exp_csb()));
    cmp("m_we",    32'(MEM_WE),       32'(TEST_EN ? TEST_MEM_WE : write_enable_MEM));
    cmp("m_addr",  32'(MEM_ADDR),     32'(eaddr));
    cmp("m_wmask", 32'(MEM_WMASK),    32'(emask));
    cmp("m_wdata", MEM_WDATA,         ewdata);
    cmp("m_valid", 32'(rdata_valid),  32'(m.valid));
    cmp("m_rdata", rdata_WB,          m.rdata);
    cmp("m_err",   32'(misalign_err), 32'(m.err));
    cmp("m_tdata", TEST_MEM_DATA,     m.tdata);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [3:0] lat, input logic [31:0] word, input logic [31:0] exp);
    int eff;
    eff = (lat == 4'd0) ? 1 : int'(lat);
    chipselect_MEM = 1'b0; write_enable_MEM = 1'b1;
    funct3_MEM = f3; addr_MEM = a; rd_latency = lat;
    #1;
    cmp({nm, "_issue_csb"}, 32'(MEM_CSB), 32'd0);
    tick();
    for (int i = 1; i < eff; i++) begin
      cmp({nm, "_wait_csb"}, 32'(MEM_CSB), 32'd1);
      cmp({nm, "_wait_valid"}, 32'(rdata_valid), 32'd0);
      tick();
    end
    cmp({nm, "_last_wait_csb"}, 32'(MEM_CSB), 32'd1);
    chipselect_MEM = 1'b1;
    MEM_RDATA = word;
    tick();
    MEM_RDATA = 32'd0;
    cmp({nm, "_valid"}, 32'(rdata_valid), 32'd1);
    cmp({nm, "_rdata"}, rdata_WB, exp);
    tick();
    cmp({nm, "_valid_fall"}, 32'(rdata_valid), 32'd0);
    cmp({nm, "_rdata_kept"}, rdata_WB, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; chipselect_MEM = 1'b1; write_enable_MEM = 1'b1;
    funct3_MEM = LW_C(); addr_MEM = 32'd0; wdata_MEM = 32'd0;
    enable_cs = 1'b0; STOP_Pipelinen = 1'b1;
    TEST_EN = 1'b1; TEST_MEM_CSB = 1'b0; TEST_MEM_WE = 1'b1;
    rd_latency = 4'd1; MEM_RDATA = 32'd0;
    #1;
    cmp("rst_csb_test_en", 32'(MEM_CSB), 32'd1);
    cmp("rst_valid", 32'(rdata_valid), 32'd0);
    cmp("rst_rdata", rdata_WB, 32'd0);
    cmp("rst_tdata", TEST_MEM_DATA, 32'd0);
    cmp("rst_err", 32'(misalign_err), 32'd0);
    TEST_EN = 1'b0; TEST_MEM_CSB = 1'b1;
    tick(); tick();
    rstn = 1'b1;

    // startup-test override
    TEST_EN = 1'b1; TEST_MEM_CSB = 1'b0; TEST_MEM_WE = 1'b0;
    #1;
    cmp("test_addr", 32'(MEM_ADDR), 32'd0);
    cmp("test_wdata", MEM_WDATA, 32'hFFFF_FFFF);
    cmp("test_wmask", 32'(MEM_WMASK), 32'hF);
    cmp("test_csb", 32'(MEM_CSB), 32'd0);
    cmp("test_we", 32'(MEM_WE), 32'd0);
    TEST_MEM_WE = 1'b1; MEM_RDATA = 32'hFFFF_FFFF;
    tick();
    cmp("test_capture", TEST_MEM_DATA, 32'hFFFF_FFFF);
    TEST_EN = 1'b0; TEST_MEM_CSB = 1'b1; MEM_RDATA = 32'h0;
    tick();
    cmp("test_data_hold", TEST_MEM_DATA, 32'hFFFF_FFFF);

    // loads: latency, lane select and extension
    do_read("lw_lat3", 3'b010, 32'h10, 4'd3, 32'h1234_5678, 32'h1234_5678);
    do_read("lb_sext", 3'b000, 32'h13, 4'd1, 32'h8000_0000, 32'hFFFF_FF80);
    do_read("lbu_zext", 3'b100, 32'h13, 4'd1, 32'h8000_0000, 32'h0000_0080);
    do_read("lh_lat0", 3'b001, 32'h12, 4'd0, 32'h8001_0000, 32'hFFFF_8001);
    do_read("lhu_lat2", 3'b101, 32'h16, 4'd2, 32'hBEEF_1234, 32'h0000_BEEF);
    do_read("lb_pos", 3'b000, 32'h11, 4'd1, 32'h0000_7F00, 32'h0000_007F);

    // stall hold, then back-to-back read on release
    chipselect_MEM = 1'b0; funct3_MEM = 3'b010; addr_MEM = 32'h20; rd_latency = 4'd2;
    tick();
    chipselect_MEM = 1'b1; STOP_Pipelinen = 1'b0;
    tick();
    MEM_RDATA = 32'hCAFE_F00D;
    tick();
    MEM_RDATA = 32'h0;
    chipselect_MEM = 1'b0; addr_MEM = 32'h24; rd_latency = 4'd1;
    for (int i = 0; i < 5; i++) begin
      #1;
      cmp("stall_valid", 32'(rdata_valid), 32'd1);
      cmp("stall_rdata", rdata_WB, 32'hCAFE_F00D);
      cmp("stall_csb", 32'(MEM_CSB), 32'd1);
      tick();
    end
    STOP_Pipelinen = 1'b1;
    #1;
    cmp("release_issue_csb", 32'(MEM_CSB), 32'd0);
    tick();
    cmp("b2b_valid_clear", 32'(rdata_valid), 32'd0);
    cmp("b2b_wait_csb", 32'(MEM_CSB), 32'd1);
    chipselect_MEM = 1'b1; MEM_RDATA = 32'h1122_3344;
    tick();
    MEM_RDATA = 32'h0;
    cmp("b2b_valid", 32'(rdata_valid), 32'd1);
    cmp("b2b_rdata", rdata_WB, 32'h1122_3344);
    tick();

    // stores and misalignment
    chipselect_MEM = 1'b0; write_enable_MEM = 1'b0; funct3_MEM = 3'b001;
    addr_MEM = 32'h22; wdata_MEM = 32'h0000_ABCD;
    #1;
    cmp("sh_wmask", 32'(MEM_WMASK), 32'hC);
    cmp("sh_wdata", MEM_WDATA, 32'hABCD_ABCD);
    cmp("sh_csb", 32'(MEM_CSB), 32'd0);
    tick();
    funct3_MEM = 3'b000; addr_MEM = 32'h21; wdata_MEM = 32'h1234_565A;
    #1;
    cmp("sb_wmask", 32'(MEM_WMASK), 32'h2);
    cmp("sb_wdata", MEM_WDATA, 32'h5A5A_5A5A);
    tick();
    cmp("store_no_err", 32'(misalign_err), 32'd0);
    write_enable_MEM = 1'b1; funct3_MEM = 3'b010; addr_MEM = 32'h21;
    #1;
    cmp("mis_csb", 32'(MEM_CSB), 32'd1);
    tick();
    cmp("mis_err_pulse", 32'(misalign_err), 32'd1);
    chipselect_MEM = 1'b1;
    tick();
    cmp("mis_err_end", 32'(misalign_err), 32'd0);
    cmp("mis_no_read", 32'(rdata_valid), 32'd0);

    // reset mid-WAIT
    chipselect_MEM = 1'b0; addr_MEM = 32'h30; rd_latency = 4'd5;
    tick();
    tick();
    #2;
    rstn = 1'b0;
    #1;
    cmp("rstw_csb", 32'(MEM_CSB), 32'd1);
    cmp("rstw_valid", 32'(rdata_valid), 32'd0);
    cmp("rstw_rdata", rdata_WB, 32'd0);
    cmp("rstw_tdata", TEST_MEM_DATA, 32'd0);
    tick();
    rstn = 1'b1;
    #1;
    cmp("rstw_idle_accepts", 32'(MEM_CSB), 32'd0);
    chipselect_MEM = 1'b1;
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  function automatic logic [2:0] LW_C();
    return 3'b010;
  endfunction

endmodule
